voice_synth: RTL
================

// Module: voice_synth
// PURPOSE
// - Downstream of the note-decode stage.
// - Consumes up to 5 decoded voices (note 0-11, octave, velocity) and runs one phase accumulator per voice.
// - Renders a velocity-scaled triangle wave per voice and mixes all voices into one unsigned sample per sample period.
// - The sample feeds the PWM output stage.
// - Voice math is time-multiplexed through a single multiply-accumulate datapath.
// PARAMETERS
// SAMPLE_DIV  2083  clk_in cycles per output sample (100 MHz -> 48 kHz); must be >= 8
// PHASE_W     24    phase accumulator width
// PORTS
// clk_in                 in   1       system clock; all logic is on its rising edge
// rst_in                 in   1       asynchronous, active-low reset
// vals_ready_in          in   1       1-cycle pulse: the voice arrays below are valid
// octave_count_in[4:0]   in   4 ea.   octave per voice (MIDI note / 12)
// note_value_in[4:0]     in   8 ea.   pitch class per voice (MIDI note % 12)
// note_velocity_in[4:0]  in   8 ea.   velocity per voice; bits [6:0] used; 0 = voice off
// sample_out             out  8       mixed sample, unsigned; 128 = silence
// sample_valid_out       out  1       1-cycle pulse when sample_out updates
// voices_active_out      out  5       bit i = 1 when voice i is currently sounding
// BEHAVIOUR
// - Reset (rst_in = 0, async):
//   - sample_out = 128; sample_valid_out = 0; voices_active_out = 0.
//   - All phases, voice registers and the pending flag clear; tick counter = 0; FSM = IDLE.
// - Tick counter:
//   - Counts 0..SAMPLE_DIV-1 and wraps; tick = (count == SAMPLE_DIV-1).
//   - Free-running and independent of FSM state.
// - Input capture:
//   - On vals_ready_in, copy all 15 fields into a pending shadow and set pending = 1 (any state).
//   - A second pulse before the shadow is applied overwrites it; the last one wins.
// - FSM: IDLE -> LOAD -> VOICE (5 cycles, i = 0..4) -> SAT -> OUT -> IDLE.
//   - IDLE: wait for tick.
//   - LOAD: if pending, copy shadow into active voice regs and clear pending.
//     - A vals_ready_in in the same cycle as LOAD is captured and stays pending for the next frame.
//     - Voice i phase is kept only if it was active and its note and octave are unchanged; otherwise phase_i = 0.
//     - Clear accumulator acc (signed 18 bit).
//   - VOICE i:
//     - Voice is muted if velocity[6:0] == 0, note > 11, or octave > 10.
//     - p = phase_i[PHASE_W-1 -: 9]; tri = p[8] ? ~p[7:0] : p[7:0].
//     - s = (tri - 128) signed 9b * vel[6:0] -> signed 16b; if not muted, acc += s.
//     - If not muted: phase_i += INC[note] << octave (mod 2^PHASE_W). Muted voice: phase held, not summed.
//   - SAT: y = (acc >>> 9) + 128, clamped to 0..255.
//   - OUT: sample_out <= y; sample_valid_out = 1 for this cycle only; voices_active_out <= unmuted mask.
// - Latency: tick at cycle t -> sample_valid_out asserted at cycle t+8.
// - Phase increments: INC is a 12-entry constant table, octave -1 (MIDI 0..11) at 48 kHz, PHASE_W = 24.
//   - INC[k] = round(8.1758 * 2^(k/12) * 2^24 / 48000).
//   - INC[0] = 2858, INC[9] = 4806.
// - Widths: max |acc| = 5*128*127 = 81280 < 2^17, so the signed 18-bit acc cannot overflow.
// - Reset mid-frame aborts the frame; no sample_valid_out pulse is produced for it.
// TESTING
// 1. Reset: hold rst_in = 0 for 5 cycles, release.
//    -> sample_out = 128, voices_active_out = 0, first sample_valid_out at cycle SAMPLE_DIV+7 after release.
// 2. Silence: no vals_ready_in. -> every sample = 128; pulses spaced exactly SAMPLE_DIV cycles.
// 3. A4: voice0 = note 9, octave 5, velocity 127.
//    -> first sample = 96, voices_active_out = 5'b00001, phase0 step 153792.
//    -> waveform period ~109.09 samples (440 Hz).
// 4. Saturation: all 5 voices = note 0, octave 4, velocity 127. -> first sample = 0 (clamped); voices_active_out = 5'b11111.
// 5. Retain vs. restart: voice0 active on A4, new burst with voice0 unchanged and voice1 newly set.
//    -> phase0 continues without reset; phase1 starts at 0.
//    -> octave 11 on voice2 -> voice2 muted, bit 2 = 0.
// 6. Pulse in LOAD: vals_ready_in coincides with LOAD.
//    -> captured data is applied at the following frame.
//    -> reset asserted mid-VOICE drives outputs to reset values immediately, with no pulse.

Source files
------------

// File: rtl/voice_synth_if.sv
// Voice bus between the note-decode stage, the synthesiser and the PWM stage.
// The decoder side drives voice data; the synthesiser returns the mixed sample.
interface voice_synth_if;
  logic                 vals_ready_in;
  logic [4:0][3:0]      octave_count_in;
  logic [4:0][7:0]      note_value_in;
  logic [4:0][7:0]      note_velocity_in;
  logic [7:0]           sample_out;
  logic                 sample_valid_out;
  logic [4:0]           voices_active_out;

  modport master (
    output vals_ready_in, octave_count_in, note_value_in, note_velocity_in,
    input  sample_out, sample_valid_out, voices_active_out
  );

  modport slave (
    input  vals_ready_in, octave_count_in, note_value_in, note_velocity_in,
    output sample_out, sample_valid_out, voices_active_out
  );
endinterface

// File: rtl/voice_synth.sv
// Five-voice triangle synthesiser: one phase accumulator per voice, voices
// rendered one per cycle through a shared multiply-accumulate, mixed per sample.
module voice_synth #(
  parameter int SAMPLE_DIV = 2083,
  parameter int PHASE_W    = 24
) (
  input  logic         clk_in,
  input  logic         rst_in,
  voice_synth_if.slave bus
);
  localparam int NV    = 5;
  localparam int CNT_W = $clog2(SAMPLE_DIV);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VOICE, S_SAT, S_OUT} state_t;
  state_t r_state, w_state_next;

  logic [CNT_W-1:0]   r_tick_cnt;
  logic               w_tick;
  logic               r_pending;
  logic [3:0]         r_sh_oct  [NV];
  logic [7:0]         r_sh_note [NV];
  logic [6:0]         r_sh_vel  [NV];
  logic [3:0]         r_oct     [NV];
  logic [7:0]         r_note    [NV];
  logic [6:0]         r_vel     [NV];
  logic [PHASE_W-1:0] r_phase   [NV];
  logic [2:0]         r_vidx;
  logic signed [17:0] r_acc;
  logic [7:0]         r_sample;
  logic               r_valid;
  logic [NV-1:0]      r_active;

  logic [NV-1:0]      w_mute;
  logic [NV-1:0]      w_keep;
  logic [PHASE_W-1:0] w_sel_phase;
  logic [8:0]         w_p;
  logic [7:0]         w_tri;
  logic signed [17:0] w_tri_s;
  logic signed [17:0] w_vel_s;
  logic signed [17:0] w_prod;
  logic [12:0]        w_inc;
  logic [PHASE_W-1:0] w_step;
  logic signed [17:0] w_acc_sh;
  logic signed [17:0] w_y_wide;
  logic [7:0]         w_y;

  // Octave -1 increments at 48 kHz for a 24-bit accumulator; higher octaves shift left.
  function automatic logic [12:0] inc_lut(input logic [7:0] note);
    case (note)
      8'd0:    inc_lut = 13'd2858;
      8'd1:    inc_lut = 13'd3028;
      8'd2:    inc_lut = 13'd3208;
      8'd3:    inc_lut = 13'd3398;
      8'd4:    inc_lut = 13'd3600;
      8'd5:    inc_lut = 13'd3815;
      8'd6:    inc_lut = 13'd4041;
      8'd7:    inc_lut = 13'd4282;
      8'd8:    inc_lut = 13'd4536;
      8'd9:    inc_lut = 13'd4806;
      8'd10:   inc_lut = 13'd5092;
      8'd11:   inc_lut = 13'd5395;
      default: inc_lut = 13'd0;
    endcase
  endfunction

  // A voice keeps its phase across a reload only if it was sounding the same pitch.
  generate
    for (genvar gi = 0; gi < NV; gi++) begin : g_voice
      assign w_mute[gi] = (r_vel[gi] == 7'd0) || (r_note[gi] > 8'd11) || (r_oct[gi] > 4'd10);
      assign w_keep[gi] = !w_mute[gi] && (r_note[gi] == r_sh_note[gi]) &&
                          (r_oct[gi] == r_sh_oct[gi]);
    end
  endgenerate

  assign w_tick      = (r_tick_cnt == CNT_W'(SAMPLE_DIV - 1));
  assign w_sel_phase = r_phase[r_vidx];
  assign w_p         = w_sel_phase[PHASE_W-1 -: 9];
  assign w_tri       = w_p[8] ? ~w_p[7:0] : w_p[7:0];
  assign w_tri_s     = $signed({10'd0, w_tri}) - 18'sd128;
  assign w_vel_s     = $signed({11'd0, r_vel[r_vidx]});
  assign w_prod      = w_tri_s * w_vel_s;
  assign w_inc       = inc_lut(r_note[r_vidx]);
  assign w_step      = {{(PHASE_W-13){1'b0}}, w_inc} << r_oct[r_vidx];
  assign w_acc_sh    = r_acc >>> 9;
  assign w_y_wide    = w_acc_sh + 18'sd128;

  always_comb begin
    w_y = w_y_wide[7:0];
    if (w_y_wide < 18'sd0)
      w_y = 8'd0;
    else if (w_y_wide > 18'sd255)
      w_y = 8'd255;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_tick_cnt <= '0;
      r_state    <= S_IDLE;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
      r_state    <= w_state_next;
    end
  end

  // OUT may go straight back to LOAD so that the minimum divider never drops a tick.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_tick) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_VOICE;
      S_VOICE: if (r_vidx == 3'(NV - 1)) w_state_next = S_SAT;
      S_SAT:   w_state_next = S_OUT;
      S_OUT:   w_state_next = w_tick ? S_LOAD : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_pending <= 1'b0;
      r_vidx    <= '0;
      r_acc     <= '0;
      r_sample  <= 8'd128;
      r_valid   <= 1'b0;
      r_active  <= '0;
      for (int i = 0; i < NV; i++) begin
        r_sh_oct[i]  <= '0;
        r_sh_note[i] <= '0;
        r_sh_vel[i]  <= '0;
        r_oct[i]     <= '0;
        r_note[i]    <= '0;
        r_vel[i]     <= '0;
        r_phase[i]   <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      // A capture in the LOAD cycle wins over the clear, so it waits for the next frame.
      if (bus.vals_ready_in) begin
        r_pending <= 1'b1;
        for (int i = 0; i < NV; i++) begin
          r_sh_oct[i]  <= bus.octave_count_in[i];
          r_sh_note[i] <= bus.note_value_in[i];
          r_sh_vel[i]  <= bus.note_velocity_in[i][6:0];
        end
      end else if (r_state == S_LOAD) begin
        r_pending <= 1'b0;
      end

      case (r_state)
        S_LOAD: begin
          r_acc  <= '0;
          r_vidx <= '0;
          if (r_pending) begin
            for (int i = 0; i < NV; i++) begin
              r_oct[i]  <= r_sh_oct[i];
              r_note[i] <= r_sh_note[i];
              r_vel[i]  <= r_sh_vel[i];
              if (!w_keep[i])
                r_phase[i] <= '0;
            end
          end
        end
        S_VOICE: begin
          r_vidx <= r_vidx + 3'd1;
          if (!w_mute[r_vidx]) begin
            r_acc            <= r_acc + w_prod;
            r_phase[r_vidx]  <= w_sel_phase + w_step;
          end
        end
        S_SAT: begin
          r_sample <= w_y;
          r_valid  <= 1'b1;
          r_active <= ~w_mute;
        end
        default: ;
      endcase
    end
  end

  assign bus.sample_out        = r_sample;
  assign bus.sample_valid_out  = r_valid;
  assign bus.voices_active_out = r_active;
endmodule
